trap_ctrl: RTL and testbench

Sequencer for the machine-level CSR unit. It arbitrates between synchronous exceptions, pending interrupts, and CSR/MRET instructions from the execute stage. It drives the CSR unit's available/op/address/value handshake and returns results and PC redirects to the core. It sits between the execute stage and the CSR unit, and is the only master of that unit.

---
 rtl/trap_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-level trap/CSR sequencer: arbitrates exceptions, interrupts and CSR/MRET ops onto the CSR unit.
// Optional TRAP_CTRL_FAULT_TRAP_EN: faulting or illegal instruction ops are converted into an illegal-instruction trap.
module trap_ctrl #(
   parameter int IRQ_PC_ALIGN = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        boundary,
   input  logic        exc_valid,
   input  logic [3:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic        ins_valid,
   input  logic [2:0]  ins_op,
   input  logic [11:0] ins_addr,
   input  logic [31:0] ins_wdata,
   input  logic [31:0] ins_pc,
   input  logic [31:0] irq_pc,
   output logic        ctrl_busy,
   output logic        done,
   output logic        done_trap,
   output logic [31:0] result,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        csr_available,
   output logic [2:0]  csr_op,
   output logic [11:0] csr_addr_exception,
   output logic [31:0] csr_write_value,
   input  logic [31:0] csr_read_value,
   input  logic        csr_busy,
   input  logic        csr_fault,
   input  logic        csr_ext_int_pending,
   input  logic        csr_sw_int_pending
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      K_TRAP = 2'd0,
      K_MRET = 2'd1,
      K_CSR  = 2'd2
   } kind_t;

   localparam logic [2:0]  OP_TRAP  = 3'b000;
   localparam logic [2:0]  OP_MRET  = 3'b001;
   localparam logic [11:0] ADDR_EXT = 12'h01B;
   localparam logic [11:0] ADDR_SW  = 12'h013;
   localparam logic [11:0] ADDR_ILL = 12'h002;
   localparam logic [31:0] PC_MASK  = ~((32'd1 << IRQ_PC_ALIGN) - 32'd1);

   state_t      state_q, state_d;
   kind_t       kind_q, kind_d;
   logic        avail_q, avail_d;
   logic [2:0]  op_q, op_d;
   logic [11:0] addr_q, addr_d;
   logic [31:0] wval_q, wval_d;
   logic [31:0] ipc_q, ipc_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        done_trap_q, done_trap_d;
   logic [31:0] result_q, result_d;
   logic        redirect_q, redirect_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   logic op_legal;
   logic busy_fall;

   assign op_legal  = (ins_op == OP_MRET) || (ins_op == 3'b101) ||
                      (ins_op == 3'b110) || (ins_op == 3'b111);
   assign busy_fall = busy_q && !csr_busy;
   assign busy_d    = csr_busy;

   always_comb begin
      state_d       = state_q;
      kind_d        = kind_q;
      avail_d       = avail_q;
      op_d          = op_q;
      addr_d        = addr_q;
      wval_d        = wval_q;
      ipc_d         = ipc_q;
      done_d        = 1'b0;
      done_trap_d   = 1'b0;
      result_d      = '0;
      redirect_d    = 1'b0;
      redirect_pc_d = '0;

      case (state_q)
         S_IDLE: begin
            if (exc_valid) begin
               kind_d  = K_TRAP;
               op_d    = OP_TRAP;
               addr_d  = {7'b0, 1'b0, exc_code};
               wval_d  = exc_pc & PC_MASK;
               avail_d = 1'b1;
               state_d = S_ISSUE;
            end else if (boundary && csr_ext_int_pending) begin
               kind_d  = K_TRAP;
               op_d    = OP_TRAP;
               addr_d  = ADDR_EXT;
               wval_d  = irq_pc & PC_MASK;
               avail_d = 1'b1;
               state_d = S_ISSUE;
            end else if (boundary && csr_sw_int_pending) begin
               kind_d  = K_TRAP;
               op_d    = OP_TRAP;
               addr_d  = ADDR_SW;
               wval_d  = irq_pc & PC_MASK;
               avail_d = 1'b1;
               state_d = S_ISSUE;
            end else if (ins_valid) begin
               kind_d = (ins_op == OP_MRET) ? K_MRET : K_CSR;
               op_d   = ins_op;
               addr_d = ins_addr;
               wval_d = ins_wdata;
               ipc_d  = ins_pc & PC_MASK;
               if (op_legal) begin
                  avail_d = 1'b1;
                  state_d = S_ISSUE;
               end else begin
                  // Illegal encodings never reach the CSR unit.
`ifdef TRAP_CTRL_FAULT_TRAP_EN
                  state_d = S_GAP;
`else
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  done_trap_d = 1'b1;
`endif
               end
            end
         end

         S_ISSUE: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (busy_fall) begin
               avail_d = 1'b0;
               if (csr_fault && kind_q != K_TRAP) begin
`ifdef TRAP_CTRL_FAULT_TRAP_EN
                  state_d = S_GAP;
`else
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  done_trap_d = 1'b1;
`endif
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  case (kind_q)
                     K_TRAP: begin
                        done_trap_d   = 1'b1;
                        redirect_d    = 1'b1;
                        redirect_pc_d = csr_read_value;
                     end
                     K_MRET: begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = csr_read_value;
                     end
                     default: result_d = csr_read_value;
                  endcase
               end
            end
         end

         S_GAP: begin
            // One idle cycle separates the faulted op from the trap reissue.
            kind_d  = K_TRAP;
            op_d    = OP_TRAP;
            addr_d  = ADDR_ILL;
            wval_d  = ipc_q;
            avail_d = 1'b1;
            state_d = S_ISSUE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            avail_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         kind_q        <= K_CSR;
         avail_q       <= 1'b0;
         op_q          <= '0;
         addr_q        <= '0;
         wval_q        <= '0;
         ipc_q         <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         done_trap_q   <= 1'b0;
         result_q      <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         kind_q        <= kind_d;
         avail_q       <= avail_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         wval_q        <= wval_d;
         ipc_q         <= ipc_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         done_trap_q   <= done_trap_d;
         result_q      <= result_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign ctrl_busy          = (state_q != S_IDLE);
   assign done               = done_q;
   assign done_trap          = done_trap_q;
   assign result             = result_q;
   assign redirect           = redirect_q;
   assign redirect_pc        = redirect_pc_q;
   assign csr_available      = avail_q;
   assign csr_op             = op_q;
   assign csr_addr_exception = addr_q;
   assign csr_write_value    = wval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl with a small behavioural CSR unit (mstatus/mtvec/mepc, 0x342 faults).
module tb_trap_ctrl;

   typedef struct {
      logic [11:0] a1;
      logic [31:0] v1;
      logic [11:0] a2;
      logic [31:0] v2;
      int          issues;
      int          lat;
      logic        trap;
      logic        redir;
      logic [31:0] rpc;
      logic [31:0] res;
      int          t0;
   } exp_t;

   logic        clk = 0, reset = 1;
   logic        boundary = 0, exc_valid = 0, ins_valid = 0;
   logic [3:0]  exc_code = 0;
   logic [31:0] exc_pc = 0, ins_wdata = 0, ins_pc = 0, irq_pc = 0;
   logic [2:0]  ins_op = 0;
   logic [11:0] ins_addr = 0;
   logic        ctrl_busy, done, done_trap, redirect, csr_available;
   logic [31:0] result, redirect_pc, csr_write_value;
   logic [2:0]  csr_op;
   logic [11:0] csr_addr_exception;
   logic [31:0] csr_read_value = 0;
   logic        csr_busy = 0, csr_fault = 0;
   logic        csr_ext_int_pending = 0, csr_sw_int_pending = 0;

   int   vecs = 0, errs = 0, cyc = 0, phase = 0, n_iss = 0;
   logic prev_av = 0, prev_done = 0;
   exp_t sb[$];
   exp_t cur;
   logic [31:0] mstatus = 0, mtvec = 32'h100, mepc = 0, mcause = 0;

   trap_ctrl #(.IRQ_PC_ALIGN(2)) dut (
      .clk(clk), .reset(reset), .boundary(boundary),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
      .ins_valid(ins_valid), .ins_op(ins_op), .ins_addr(ins_addr),
      .ins_wdata(ins_wdata), .ins_pc(ins_pc), .irq_pc(irq_pc),
      .ctrl_busy(ctrl_busy), .done(done), .done_trap(done_trap), .result(result),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .csr_available(csr_available), .csr_op(csr_op),
      .csr_addr_exception(csr_addr_exception), .csr_write_value(csr_write_value),
      .csr_read_value(csr_read_value), .csr_busy(csr_busy), .csr_fault(csr_fault),
      .csr_ext_int_pending(csr_ext_int_pending), .csr_sw_int_pending(csr_sw_int_pending)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [11:0] a1, input logic [31:0] v1,
                               input logic [11:0] a2, input logic [31:0] v2,
                               input int iss, input int lat, input logic trap,
                               input logic redir, input logic [31:0] rpc, input logic [31:0] res);
      exp_t e;
      e.a1 = a1; e.v1 = v1; e.a2 = a2; e.v2 = v2; e.issues = iss; e.lat = lat;
      e.trap = trap; e.redir = redir; e.rpc = rpc; e.res = res; e.t0 = 0;
      return e;
   endfunction

   // CSR unit: busy in the 2nd cycle of csr_available, result on the falling edge of busy.
   task automatic csr_exec();
      logic [31:0] old, nw;
      csr_fault = 0;
      old = 0;
      if (csr_op == 3'b000) begin
         mepc = csr_write_value;
         mcause = {20'b0, csr_addr_exception};
         csr_read_value = mtvec;
      end else if (csr_op == 3'b001) begin
         csr_read_value = mepc;
      end else if (csr_addr_exception == 12'h300 || csr_addr_exception == 12'h305 ||
                   csr_addr_exception == 12'h341) begin
         case (csr_addr_exception)
            12'h300: old = mstatus;
            12'h305: old = mtvec;
            default: old = mepc;
         endcase
         case (csr_op)
            3'b101:  nw = csr_write_value;
            3'b110:  nw = old | csr_write_value;
            default: nw = old & ~csr_write_value;
         endcase
         case (csr_addr_exception)
            12'h300: mstatus = nw;
            12'h305: mtvec = nw;
            default: mepc = nw;
         endcase
         csr_read_value = old;
      end else begin
         csr_fault = 1;
         csr_read_value = 32'hDEADBEEF;
      end
   endtask

   always @(negedge clk) begin
      if (reset || !csr_available) begin
         phase = 0;
         csr_busy = 0;
      end else begin
         case (phase)
            0: phase = 1;
            1: begin csr_busy = 1; phase = 2; end
            2: begin csr_busy = 0; csr_exec(); phase = 3; end
            default: ;
         endcase
      end
   end

   // Scoreboard monitor: issue addresses on each rise of csr_available, results on done.
   always @(negedge clk) begin
      if (reset) begin
         prev_av = 0; prev_done = 0; n_iss = 0;
      end else begin
         if (csr_available && !prev_av && sb.size() > 0) begin
            if (n_iss == 0) begin
               chk("issue_addr", csr_addr_exception, sb[0].a1);
               chk("issue_val", csr_write_value, sb[0].v1);
            end else begin
               chk("reissue_op", csr_op, 3'b000);
               chk("reissue_addr", csr_addr_exception, sb[0].a2);
               chk("reissue_val", csr_write_value, sb[0].v2);
            end
            n_iss++;
         end
         if (done) begin
            chk("done_pulse", prev_done, 0);
            if (sb.size() == 0) chk("spurious_done", done, 0);
            else begin
               cur = sb.pop_front();
               chk("latency", cyc - cur.t0, cur.lat);
               chk("issues", n_iss, cur.issues);
               chk("done_trap", done_trap, cur.trap);
               chk("redirect", redirect, cur.redir);
               chk("redirect_pc", redirect_pc, cur.rpc);
               chk("result", result, cur.res);
               n_iss = 0;
            end
         end else begin
            chk("idle_zero", {done_trap, redirect, redirect_pc, result}, 0);
         end
         prev_av = csr_available;
         prev_done = done;
      end
   end

   task automatic clear_in();
      boundary = 0; exc_valid = 0; ins_valid = 0; exc_code = 0; exc_pc = 0;
      ins_op = 0; ins_addr = 0; ins_wdata = 0; ins_pc = 0; irq_pc = 0;
      csr_ext_int_pending = 0; csr_sw_int_pending = 0;
   endtask

   task automatic req(input logic bnd, input logic ext, input logic sw,
                      input logic ev, input logic [3:0] code, input logic [31:0] epc,
                      input logic iv, input logic [2:0] op, input logic [11:0] ad,
                      input logic [31:0] wd, input logic [31:0] ipc, input logic [31:0] qpc,
                      input exp_t e);
      int k;
      k = 0;
      while (ctrl_busy && k < 50) begin @(negedge clk); k++; end
      boundary = bnd; csr_ext_int_pending = ext; csr_sw_int_pending = sw;
      exc_valid = ev; exc_code = code; exc_pc = epc;
      ins_valid = iv; ins_op = op; ins_addr = ad; ins_wdata = wd; ins_pc = ipc; irq_pc = qpc;
      e.t0 = cyc;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      clear_in();
      k = 0;
      while (sb.size() > 0 && k < 40) begin @(negedge clk); k++; end
      if (sb.size() > 0) begin
         chk("timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   initial begin
      clear_in();
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {ctrl_busy, done, csr_available}, 0);
      reset = 0;
      @(negedge clk);
      chk("rst_csr", {csr_op, csr_addr_exception, csr_write_value}, 0);

      // CSR read/modify/write
      req(0,0,0, 0,0,0, 1,3'b101,12'h300,32'h8,32'h0,32'h0, mk(12'h300,32'h8,0,0,1,4,0,0,0,32'h0));
      req(0,0,0, 0,0,0, 1,3'b110,12'h300,32'h0,32'h0,32'h0, mk(12'h300,32'h0,0,0,1,4,0,0,0,32'h8));
      // exception beats a simultaneous instruction; PC is aligned
      req(0,0,0, 1,4'hB,32'h1002, 1,3'b101,12'h300,32'h77,32'h0,32'h0,
          mk(12'h00B,32'h1000,0,0,1,4,1,1,32'h100,0));
      // interrupts: ext over sw, then sw, then masked by boundary=0
      req(1,1,1, 0,0,0, 0,0,0,0,0,32'h202, mk(12'h01B,32'h200,0,0,1,4,1,1,32'h100,0));
      req(1,0,1, 0,0,0, 0,0,0,0,0,32'h200, mk(12'h013,32'h200,0,0,1,4,1,1,32'h100,0));
      req(0,1,1, 0,0,0, 1,3'b110,12'h341,32'h0,32'h0,32'h200, mk(12'h341,32'h0,0,0,1,4,0,0,0,32'h200));
      // MRET returns to mepc
      req(0,0,0, 0,0,0, 1,3'b001,12'h302,32'h0,32'h0,32'h0, mk(12'h302,32'h0,0,0,1,4,0,1,32'h200,0));
      req(0,0,0, 0,0,0, 1,3'b111,12'h300,32'h8,32'h0,32'h0, mk(12'h300,32'h8,0,0,1,4,0,0,0,32'h8));
      req(0,0,0, 0,0,0, 1,3'b110,12'h300,32'h0,32'h0,32'h0, mk(12'h300,32'h0,0,0,1,4,0,0,0,32'h0));
      // faulting CSR write
`ifdef TRAP_CTRL_FAULT_TRAP_EN
      req(0,0,0, 0,0,0, 1,3'b101,12'h342,32'h5,32'h3006,32'h0,
          mk(12'h342,32'h5,12'h002,32'h3004,2,8,1,1,32'h100,0));
`else
      req(0,0,0, 0,0,0, 1,3'b101,12'h342,32'h5,32'h3006,32'h0,
          mk(12'h342,32'h5,0,0,1,4,1,0,0,0));
`endif

      // reset in WAIT abandons the pending write to mstatus
      ins_valid = 1; ins_op = 3'b101; ins_addr = 12'h300; ins_wdata = 32'h55;
      @(posedge clk); @(negedge clk);
      clear_in();
      @(posedge clk); @(negedge clk);
      chk("wait_busy", ctrl_busy, 1);
      reset = 1;
      #1;
      chk("mid_rst_avail", csr_available, 0);
      chk("mid_rst_busy", ctrl_busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_csr", {csr_op, csr_addr_exception, csr_write_value}, 0);
      repeat (2) @(negedge clk);
      reset = 0;
      @(negedge clk);
      req(0,0,0, 0,0,0, 1,3'b110,12'h300,32'h0,32'h0,32'h0, mk(12'h300,32'h0,0,0,1,4,0,0,0,32'h0));

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
